// File: rtl/calendar_date.sv
// calendar_date
//   Gregorian day/month/year counter driven by the clock timer's day_end
//   level, with three manual set buttons for date editing. Outputs BCD
//   digits for the text renderer plus leap_year and days_in_month.
//
// Ports
//   clk                     system clock
//   reset                   synchronous, active-high reset
//   day_end                 level from clock timer; rising edge advances one day
//   day_inc                 raw button; +1 day, wraps within the month
//   month_inc               raw button; +1 month, wraps within the year, clamps day
//   year_inc                raw button; +1 year, wraps to MIN_YEAR, clamps Feb 29
//   day_tens/day_ones       BCD day 01..31
//   month_tens/month_ones   BCD month 01..12
//   year_thou..year_ones    BCD year
//   leap_year               current year is a leap year
//   days_in_month           length of current month (28..31)
module calendar_date #(
    parameter int MIN_YEAR   = 2000,
    parameter int MAX_YEAR   = 2099,
    parameter int START_YEAR = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       day_end,
    input  logic       day_inc,
    input  logic       month_inc,
    input  logic       year_inc,
    output logic [3:0] day_ones,
    output logic [3:0] day_tens,
    output logic [3:0] month_ones,
    output logic [3:0] month_tens,
    output logic [3:0] year_ones,
    output logic [3:0] year_tens,
    output logic [3:0] year_hund,
    output logic [3:0] year_thou,
    output logic       leap_year,
    output logic [4:0] days_in_month
);

    localparam logic [6:0]  YEAR_SPAN    = 7'(MAX_YEAR - MIN_YEAR);
    localparam logic [6:0]  START_OFFSET = 7'(START_YEAR - MIN_YEAR);
    localparam logic [11:0] MIN_YEAR_BIN = 12'(MIN_YEAR);

    // Bit positions in the conditioned input vectors.
    localparam int unsigned EV_ADV   = 0;
    localparam int unsigned EV_DAY   = 1;
    localparam int unsigned EV_MONTH = 2;
    localparam int unsigned EV_YEAR  = 3;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                     return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
            default:                  return 5'd31;
        endcase
    endfunction

    // MIN_YEAR is a multiple of 400, so divisibility by 4 of the offset
    // equals divisibility by 4 of the full year across the whole window.
    function automatic logic offset_is_leap(input logic [6:0] off);
        return (off[1:0] == 2'b00);
    endfunction

    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [3:0]  sync3_q, sync3_d;
    logic [3:0]  ev;

    logic [4:0]  day_q,   day_d;
    logic [3:0]  month_q, month_d;
    logic [6:0]  year_q,  year_d;

    logic [11:0] year_bin;
    logic        leap_cur;
    logic [4:0]  dim_cur;
    logic [3:0]  month_next;
    logic [6:0]  year_next;
    logic [4:0]  dim_new;

    always_comb begin
        sync1_d = {year_inc, month_inc, day_inc, day_end};
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        ev      = sync2_q & ~sync3_q;
    end

    always_comb begin
        leap_cur   = offset_is_leap(year_q);
        dim_cur    = month_len(month_q, leap_cur);
        month_next = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
        year_next  = (year_q >= YEAR_SPAN) ? 7'd0 : year_q + 7'd1;
        dim_new    = 5'd31;

        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;

        // Fixed priority; lower-priority events in the same cycle are dropped.
        if (ev[EV_ADV]) begin
            if (day_q < dim_cur) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d   = 5'd1;
                month_d = month_next;
                if (month_q == 4'd12) begin
                    year_d = year_next;
                end
            end
        end else if (ev[EV_DAY]) begin
            day_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
        end else if (ev[EV_MONTH]) begin
            month_d = month_next;
            dim_new = month_len(month_next, leap_cur);
            day_d   = (day_q > dim_new) ? dim_new : day_q;
        end else if (ev[EV_YEAR]) begin
            year_d  = year_next;
            dim_new = month_len(month_q, offset_is_leap(year_next));
            day_d   = (day_q > dim_new) ? dim_new : day_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            day_q   <= 5'd1;
            month_q <= 4'd1;
            year_q  <= START_OFFSET;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
        end
    end

    always_comb begin
        year_bin      = MIN_YEAR_BIN + {5'd0, year_q};
        leap_year     = leap_cur;
        days_in_month = dim_cur;
        day_tens      = 4'(day_q / 5'd10);
        day_ones      = 4'(day_q % 5'd10);
        month_tens    = 4'(month_q / 4'd10);
        month_ones    = 4'(month_q % 4'd10);
        year_thou     = 4'(year_bin / 12'd1000);
        year_hund     = 4'((year_bin / 12'd100) % 12'd10);
        year_tens     = 4'((year_bin / 12'd10) % 12'd10);
        year_ones     = 4'(year_bin % 12'd10);
    end

endmodule

// File: tb/tb_calendar_date.sv
module tb_calendar_date;

    logic       clk;
    logic       reset;
    logic [3:0] btn;   // {year_inc, month_inc, day_inc, day_end}
    logic [3:0] day_ones, day_tens, month_ones, month_tens;
    logic [3:0] year_ones, year_tens, year_hund, year_thou;
    logic       leap_year;
    logic [4:0] days_in_month;
    logic [31:0] date_w;   // DD MM YYYY as BCD nibbles

    int checks = 0;
    int passes = 0;

    calendar_date #(.MIN_YEAR(2000), .MAX_YEAR(2099), .START_YEAR(2000)) dut (
        .clk           (clk),
        .reset         (reset),
        .day_end       (btn[0]),
        .day_inc       (btn[1]),
        .month_inc     (btn[2]),
        .year_inc      (btn[3]),
        .day_ones      (day_ones),
        .day_tens      (day_tens),
        .month_ones    (month_ones),
        .month_tens    (month_tens),
        .year_ones     (year_ones),
        .year_tens     (year_tens),
        .year_hund     (year_hund),
        .year_thou     (year_thou),
        .leap_year     (leap_year),
        .days_in_month (days_in_month)
    );

    assign date_w = {day_tens, day_ones, month_tens, month_ones,
                     year_thou, year_hund, year_tens, year_ones};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic press_n(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            btn[idx] = 1'b1;
            tick();
            btn[idx] = 1'b0;
            tick();
        end
        settle();
    endtask

    task automatic do_reset();
        btn   = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    // Reach DD/MM/YYYY from 01/01/2000 using the set buttons.
    task automatic set_date(input int d, input int m, input int y);
        do_reset();
        press_n(3, y - 2000);
        press_n(2, m - 1);
        press_n(1, d - 1);
    endtask

    task automatic test_reset();
        btn   = '0;
        reset = 1'b1;
        tick();
        checks++;
        if (date_w !== 32'h0101_2000) $display("FAIL reset_first_edge: got %h expected %h", date_w, 32'h0101_2000);
        else passes++;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        checks++;
        if (date_w !== 32'h0101_2000) $display("FAIL reset_idle_date: got %h expected %h", date_w, 32'h0101_2000);
        else passes++;
        checks++;
        if (leap_year !== 1'b1) $display("FAIL reset_leap: got %b expected 1", leap_year);
        else passes++;
        checks++;
        if (days_in_month !== 5'd31) $display("FAIL reset_dim: got %0d expected 31", days_in_month);
        else passes++;
    endtask

    task automatic test_day_end_hold();
        do_reset();
        btn[0] = 1'b1;
        tick();   // edge k
        checks++;
        if (date_w !== 32'h0101_2000) $display("FAIL hold_edge_k: got %h expected %h", date_w, 32'h0101_2000);
        else passes++;
        tick();   // edge k+1
        checks++;
        if (date_w !== 32'h0101_2000) $display("FAIL hold_edge_k1: got %h expected %h", date_w, 32'h0101_2000);
        else passes++;
        tick();   // edge k+2
        checks++;
        if (date_w !== 32'h0201_2000) $display("FAIL hold_edge_k2: got %h expected %h", date_w, 32'h0201_2000);
        else passes++;
        repeat (17) tick();
        checks++;
        if (date_w !== 32'h0201_2000) $display("FAIL hold_no_repeat: got %h expected %h", date_w, 32'h0201_2000);
        else passes++;
        btn[0] = 1'b0;
        settle();
    endtask

    task automatic test_february();
        set_date(28, 2, 2001);
        checks++;
        if (date_w !== 32'h2802_2001) $display("FAIL feb01_setup: got %h expected %h", date_w, 32'h2802_2001);
        else passes++;
        checks++;
        if (leap_year !== 1'b0 || days_in_month !== 5'd28)
            $display("FAIL feb01_len: got leap=%b dim=%0d expected leap=0 dim=28", leap_year, days_in_month);
        else passes++;
        press_n(0, 1);
        checks++;
        if (date_w !== 32'h0103_2001) $display("FAIL feb01_advance: got %h expected %h", date_w, 32'h0103_2001);
        else passes++;
        checks++;
        if (days_in_month !== 5'd31) $display("FAIL mar_dim: got %0d expected 31", days_in_month);
        else passes++;

        set_date(28, 2, 2000);
        checks++;
        if (leap_year !== 1'b1 || days_in_month !== 5'd29)
            $display("FAIL feb00_len: got leap=%b dim=%0d expected leap=1 dim=29", leap_year, days_in_month);
        else passes++;
        press_n(0, 1);
        checks++;
        if (date_w !== 32'h2902_2000) $display("FAIL feb00_to_29: got %h expected %h", date_w, 32'h2902_2000);
        else passes++;
        press_n(0, 1);
        checks++;
        if (date_w !== 32'h0103_2000) $display("FAIL feb00_to_mar: got %h expected %h", date_w, 32'h0103_2000);
        else passes++;

        set_date(1, 4, 2000);
        checks++;
        if (days_in_month !== 5'd30) $display("FAIL apr_dim: got %0d expected 30", days_in_month);
        else passes++;
    endtask

    task automatic test_year_wrap();
        set_date(31, 12, 2099);
        checks++;
        if (date_w !== 32'h3112_2099) $display("FAIL wrap_setup: got %h expected %h", date_w, 32'h3112_2099);
        else passes++;
        checks++;
        if (leap_year !== 1'b0) $display("FAIL wrap_leap2099: got %b expected 0", leap_year);
        else passes++;
        press_n(0, 1);
        checks++;
        if (date_w !== 32'h0101_2000) $display("FAIL wrap_advance: got %h expected %h", date_w, 32'h0101_2000);
        else passes++;

        set_date(1, 1, 2099);
        press_n(3, 1);
        checks++;
        if (date_w !== 32'h0101_2000) $display("FAIL wrap_year_inc: got %h expected %h", date_w, 32'h0101_2000);
        else passes++;
    endtask

    task automatic test_set_buttons();
        set_date(31, 1, 2001);
        press_n(2, 1);
        checks++;
        if (date_w !== 32'h2802_2001) $display("FAIL month_clamp: got %h expected %h", date_w, 32'h2802_2001);
        else passes++;

        set_date(29, 2, 2004);
        checks++;
        if (date_w !== 32'h2902_2004) $display("FAIL leap_setup: got %h expected %h", date_w, 32'h2902_2004);
        else passes++;
        press_n(3, 1);
        checks++;
        if (date_w !== 32'h2802_2005) $display("FAIL year_clamp: got %h expected %h", date_w, 32'h2802_2005);
        else passes++;

        set_date(31, 1, 2000);
        press_n(1, 1);
        checks++;
        if (date_w !== 32'h0101_2000) $display("FAIL day_wrap: got %h expected %h", date_w, 32'h0101_2000);
        else passes++;

        set_date(1, 12, 2000);
        press_n(2, 1);
        checks++;
        if (date_w !== 32'h0101_2000) $display("FAIL month_wrap: got %h expected %h", date_w, 32'h0101_2000);
        else passes++;
    endtask

    task automatic test_simultaneous();
        set_date(15, 3, 2000);
        btn[0] = 1'b1;
        btn[2] = 1'b1;
        tick();
        btn = '0;
        settle();
        checks++;
        if (date_w !== 32'h1603_2000) $display("FAIL simultaneous: got %h expected %h", date_w, 32'h1603_2000);
        else passes++;
    endtask

    task automatic test_reset_mid_press();
        set_date(5, 6, 2010);
        btn[1] = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (date_w !== 32'h0101_2000) $display("FAIL midpress_reset: got %h expected %h", date_w, 32'h0101_2000);
        else passes++;
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (date_w !== 32'h0101_2000) $display("FAIL midpress_early: got %h expected %h", date_w, 32'h0101_2000);
        else passes++;
        tick();
        checks++;
        if (date_w !== 32'h0201_2000) $display("FAIL midpress_event: got %h expected %h", date_w, 32'h0201_2000);
        else passes++;
        repeat (10) tick();
        checks++;
        if (date_w !== 32'h0201_2000) $display("FAIL midpress_single: got %h expected %h", date_w, 32'h0201_2000);
        else passes++;
        btn = '0;
        settle();
    endtask

    initial begin
        reset = 1'b1;
        btn   = '0;
        test_reset();
        test_day_end_hold();
        test_february();
        test_year_wrap();
        test_set_buttons();
        test_simultaneous();
        test_reset_mid_press();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
